dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
// Shares the single-port data memory between the core's load/store path (CPU port)
// and an external loader/debug master (EXT port). Fixed CPU priority with a starvation
// counter that guarantees EXT a slot. Sequences each access as issue -> read wait -> done,
// and drives cpu_stall so the single-cycle core holds its PC until its access completes.
// PARAMETERS
// ADDR_W    32  address width, all ports
// DATA_W    32  data width, all ports
// RD_LAT    1   memory read latency in edges after issue; legal range 1..7
// MAX_WAIT  4   consecutive CPU grants while ext_req is high before EXT is forced; legal range 1..15
// PORTS
// clk         in   1       clock, rising edge
// reset       in   1       asynchronous, active-low reset
// cpu_req     in   1       CPU access request: load or store decoded
// cpu_we      in   1       CPU store (1) / load (0)
// cpu_addr    in   ADDR_W  CPU address (ALU result)
// cpu_wdata   in   DATA_W  CPU store data (rs2 value)
// cpu_stall   out  1       combinational; hold PC and regfile write
// cpu_rdata   out  DATA_W  CPU load data, valid while cpu_rvalid=1
// cpu_rvalid  out  1       1-cycle pulse, CPU load complete
// ext_req     in   1       EXT request; held stable until ext_gnt
// ext_we      in   1       EXT write (1) / read (0)
// ext_addr    in   ADDR_W  EXT address
// ext_wdata   in   DATA_W  EXT write data
// ext_gnt     out  1       1-cycle pulse in EXT issue cycle; EXT may change request next cycle
// ext_rdata   out  DATA_W  EXT read data, valid while ext_rvalid=1
// ext_rvalid  out  1       1-cycle pulse, EXT read complete
// mem_en      out  1       memory access strobe (registered)
// mem_we      out  1       memory write enable (registered)
// mem_addr    out  ADDR_W  memory address (registered)
// mem_wdata   out  DATA_W  memory write data (registered)
// mem_rdata   in   DATA_W  memory read data, valid RD_LAT edges after the issue-cycle edge
// busy        out  1       1 in any state other than IDLE
// owner       out  1       0=CPU, 1=EXT; owner of the current/last transaction
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE. All outputs 0: mem_*, *_rdata, *_rvalid, ext_gnt, busy, owner.
//   Starvation count=0. An in-flight access is dropped; no rvalid is produced for it.
// - FSM states: IDLE, ISSUE, WAIT, DONE. Requests are sampled only in IDLE.
// - IDLE: at an edge with a request present, latch winner we/addr/wdata into mem_* regs,
//   set owner, go ISSUE. With no request present, stay in IDLE.
// - Arbitration: CPU wins unless ext_req=1 and count==MAX_WAIT, in which case EXT wins.
//   count+1 (saturating) on each CPU grant while ext_req=1. count=0 on each EXT grant.
// - ISSUE (1 cycle): mem_en=1; ext_gnt=1 if owner=EXT.
//   Write: next state IDLE. Read: next state WAIT, wait counter=RD_LAT.
// - WAIT: hold for RD_LAT cycles with mem_en=0. On the last WAIT edge, capture mem_rdata
//   into the owner's rdata reg, then go DONE.
// - DONE (1 cycle): owner's rvalid=1, then IDLE. rdata holds until the next capture.
// - Latency from sampling edge: write committed at end of ISSUE (2 cycles); read rvalid in
//   cycle 2+RD_LAT after the sampling edge. Back-to-back throughput:
//   write 1 per 2 cycles, read 1 per 3+RD_LAT cycles.
// - cpu_stall = cpu_req & ~((state==ISSUE & owner==CPU & mem_we) | (state==DONE & owner==CPU)).
//   The core advances on the edge ending the completion cycle. State returns to IDLE on that
//   same edge, so one instruction never issues twice.
// - mem_en is 0 outside ISSUE. mem_addr/mem_wdata/mem_we hold their last values.
// - Simultaneous cpu_req and ext_req at count<MAX_WAIT: CPU wins; EXT keeps waiting with ext_gnt=0.
// - Request dropped while pending (not granted): ignored, no side effects.
// TESTING
// 1) Reset low mid-read (state WAIT, RD_LAT=3) -> next cycle all outputs 0, state IDLE, no cpu_rvalid ever.
// 2) CPU store addr=0x10 data=0xDEADBEEF -> mem_en=mem_we=1 one cycle later; cpu_stall low in that cycle only.
// 3) CPU load 0x10, RD_LAT=1 -> cpu_rvalid in cycle 3 after sample, cpu_rdata=0xDEADBEEF; stall 1,1,1,0.
// 4) cpu_req and ext_req held high continuously, MAX_WAIT=4 -> grant order C,C,C,C,E,C,C,C,C,E.
// 5) EXT read 0x20 (mem=0x12345678) -> ext_gnt pulse in ISSUE; ext_rvalid=1, ext_rdata=0x12345678; cpu_rvalid=0.
// 6) Sweep RD_LAT=1,2,7 with back-to-back CPU loads -> rvalid spacing = 3+RD_LAT cycles; data matches memory model.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between the core's load/store path (CPU)
// and an external loader/debug master (EXT). The CPU has fixed priority. A
// starvation counter forces an EXT grant after MAX_WAIT consecutive CPU grants
// that were made while EXT was waiting. Each access runs through the sequence
// IDLE -> ISSUE -> (WAIT x RD_LAT -> DONE for reads) -> IDLE.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata CPU access request (held while cpu_stall=1)
//   cpu_stall             combinational hold for the single-cycle core
//   cpu_rdata/cpu_rvalid  CPU load data and its one-cycle completion pulse
//   ext_req/we/addr/wdata EXT access request (held until ext_gnt)
//   ext_gnt               one-cycle pulse in the EXT issue cycle
//   ext_rdata/ext_rvalid  EXT read data and its one-cycle completion pulse
//   mem_en/we/addr/wdata  registered memory strobe and command
//   mem_rdata             memory read data, valid RD_LAT edges after issue
//   busy                  1 whenever the FSM is outside IDLE
//   owner                 0=CPU, 1=EXT for the current/last transaction
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] RD_LAT_C   = 3'(RD_LAT);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic       OWN_CPU    = 1'b0;
    localparam logic       OWN_EXT    = 1'b1;

    state_t              state_r, state_s;
    logic [3:0]          count_r, count_s;
    logic [2:0]          wait_r, wait_s;
    logic                owner_r, owner_s;
    logic                mem_en_r, mem_en_s;
    logic                mem_we_r, mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
    logic [DATA_W-1:0]   cpu_rdata_r, cpu_rdata_s;
    logic                cpu_rvalid_r, cpu_rvalid_s;
    logic [DATA_W-1:0]   ext_rdata_r, ext_rdata_s;
    logic                ext_rvalid_r, ext_rvalid_s;
    logic                ext_gnt_r, ext_gnt_s;
    logic                busy_r, busy_s;
    logic                ext_forced_s;

    // Next-state and next-output computation; every output is registered from these values.
    always_comb begin
        state_s      = state_r;
        count_s      = count_r;
        wait_s       = wait_r;
        owner_s      = owner_r;
        mem_en_s     = 1'b0;
        mem_we_s     = mem_we_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        cpu_rdata_s  = cpu_rdata_r;
        cpu_rvalid_s = 1'b0;
        ext_rdata_s  = ext_rdata_r;
        ext_rvalid_s = 1'b0;
        ext_gnt_s    = 1'b0;
        ext_forced_s = ext_req & (count_r == MAX_WAIT_C);

        case (state_r)
            ST_IDLE: begin
                if (cpu_req && !ext_forced_s) begin
                    owner_s     = OWN_CPU;
                    mem_en_s    = 1'b1;
                    mem_we_s    = cpu_we;
                    mem_addr_s  = cpu_addr;
                    mem_wdata_s = cpu_wdata;
                    state_s     = ST_ISSUE;
                    // Only CPU grants that overtake a waiting EXT count towards starvation.
                    if (ext_req && (count_r != 4'hF)) begin
                        count_s = count_r + 4'd1;
                    end else begin
                        count_s = count_r;
                    end
                end else if (ext_req) begin
                    owner_s     = OWN_EXT;
                    mem_en_s    = 1'b1;
                    mem_we_s    = ext_we;
                    mem_addr_s  = ext_addr;
                    mem_wdata_s = ext_wdata;
                    ext_gnt_s   = 1'b1;
                    count_s     = 4'd0;
                    state_s     = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_we_r) begin
                    state_s = ST_IDLE;
                end else begin
                    wait_s  = RD_LAT_C;
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Capture on the last WAIT edge, when the memory data has arrived.
                if (wait_r <= 3'd1) begin
                    state_s = ST_DONE;
                    if (owner_r == OWN_EXT) begin
                        ext_rdata_s  = mem_rdata;
                        ext_rvalid_s = 1'b1;
                    end else begin
                        cpu_rdata_s  = mem_rdata;
                        cpu_rvalid_s = 1'b1;
                    end
                end else begin
                    wait_s = wait_r - 3'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and registered-output storage with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            count_r      <= 4'd0;
            wait_r       <= 3'd0;
            owner_r      <= 1'b0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            cpu_rdata_r  <= '0;
            cpu_rvalid_r <= 1'b0;
            ext_rdata_r  <= '0;
            ext_rvalid_r <= 1'b0;
            ext_gnt_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            wait_r       <= wait_s;
            owner_r      <= owner_s;
            mem_en_r     <= mem_en_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            cpu_rdata_r  <= cpu_rdata_s;
            cpu_rvalid_r <= cpu_rvalid_s;
            ext_rdata_r  <= ext_rdata_s;
            ext_rvalid_r <= ext_rvalid_s;
            ext_gnt_r    <= ext_gnt_s;
            busy_r       <= busy_s;
        end
    end

    // The core may advance in the cycle its store issues or its load completes;
    // the FSM leaves that state on the same edge, so the access never repeats.
    assign cpu_stall = cpu_req &
                       ~(((state_r == ST_ISSUE) & (owner_r == OWN_CPU) & mem_we_r) |
                         ((state_r == ST_DONE)  & (owner_r == OWN_CPU)));

    assign mem_en     = mem_en_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign cpu_rdata  = cpu_rdata_r;
    assign cpu_rvalid = cpu_rvalid_r;
    assign ext_rdata  = ext_rdata_r;
    assign ext_rvalid = ext_rvalid_r;
    assign ext_gnt    = ext_gnt_r;
    assign busy       = busy_r;
    assign owner      = owner_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Four arbiter instances (RD_LAT = 1, 2, 3, 7; MAX_WAIT = 4), each with its own
// memory model. Directed scenario tasks compare against hand-computed values.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int NL = 4;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic        cpu_req    [NL];
    logic        cpu_we     [NL];
    logic [31:0] cpu_addr   [NL];
    logic [31:0] cpu_wdata  [NL];
    logic        cpu_stall  [NL];
    logic [31:0] cpu_rdata  [NL];
    logic        cpu_rvalid [NL];
    logic        ext_req    [NL];
    logic        ext_we     [NL];
    logic [31:0] ext_addr   [NL];
    logic [31:0] ext_wdata  [NL];
    logic        ext_gnt    [NL];
    logic [31:0] ext_rdata  [NL];
    logic        ext_rvalid [NL];
    logic        mem_en     [NL];
    logic        mem_we     [NL];
    logic [31:0] mem_addr   [NL];
    logic [31:0] mem_wdata  [NL];
    logic        busy       [NL];
    logic        owner      [NL];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < NL; g++) begin : lane
            localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 7;
            logic [31:0] mrd;
            logic [31:0] mem  [64];
            logic [31:0] pipe [8];

            dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT), .MAX_WAIT(4)) dut (
                .clk(clk), .reset(reset),
                .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
                .cpu_wdata(cpu_wdata[g]), .cpu_stall(cpu_stall[g]),
                .cpu_rdata(cpu_rdata[g]), .cpu_rvalid(cpu_rvalid[g]),
                .ext_req(ext_req[g]), .ext_we(ext_we[g]), .ext_addr(ext_addr[g]),
                .ext_wdata(ext_wdata[g]), .ext_gnt(ext_gnt[g]),
                .ext_rdata(ext_rdata[g]), .ext_rvalid(ext_rvalid[g]),
                .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
                .mem_wdata(mem_wdata[g]), .mem_rdata(mrd),
                .busy(busy[g]), .owner(owner[g])
            );

            // Synchronous memory: read data walks an RD_LAT-deep pipe; junk outside valid slots.
            always @(posedge clk) begin
                if (mem_en[g] && mem_we[g]) mem[mem_addr[g][7:2]] <= mem_wdata[g];
                if (mem_en[g] && !mem_we[g]) pipe[0] <= mem[mem_addr[g][7:2]];
                else pipe[0] <= 32'hBAD0_0000 | 32'(g);
                for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
            end
            assign mrd = pipe[LAT-1];
        end
    endgenerate

    function automatic int lat_of(input int l);
        case (l)
            0: return 1;
            1: return 2;
            2: return 3;
            default: return 7;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [135:0] v;
        reset = 1'b0;
        for (int l = 0; l < NL; l++) begin
            cpu_req[l] = 1'b0; cpu_we[l] = 1'b0; cpu_addr[l] = 32'd0; cpu_wdata[l] = 32'd0;
            ext_req[l] = 1'b0; ext_we[l] = 1'b0; ext_addr[l] = 32'd0; ext_wdata[l] = 32'd0;
        end
        tick();
        tick();
        for (int l = 0; l < NL; l++) begin
            v = {mem_en[l], mem_we[l], mem_addr[l], mem_wdata[l], cpu_rdata[l], cpu_rvalid[l],
                 ext_rdata[l], ext_rvalid[l], ext_gnt[l], busy[l], owner[l], cpu_stall[l]};
            total++;
            if (v !== 136'd0) begin
                bad++;
                $display("FAIL reset_outputs lane=%0d got=%h want=0", l, v);
            end
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_cpu_store();
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 32'h10; cpu_wdata[0] = 32'hDEADBEEF;
        #1;
        total++;
        if (cpu_stall[0] !== 1'b1) begin
            bad++; $display("FAIL store_stall_idle got=%b want=1", cpu_stall[0]);
        end
        tick();
        total++;
        if ({mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], owner[0], busy[0]} !==
            {1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL store_issue got en=%b we=%b a=%h d=%h own=%b busy=%b want 1 1 10 deadbeef 0 1",
                     mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], owner[0], busy[0]);
        end
        total++;
        if (cpu_stall[0] !== 1'b0) begin
            bad++; $display("FAIL store_stall_issue got=%b want=0", cpu_stall[0]);
        end
        cpu_req[0] = 1'b0;
        tick();
        total++;
        if ({mem_en[0], busy[0], mem_addr[0]} !== {1'b0, 1'b0, 32'h10}) begin
            bad++;
            $display("FAIL store_after got en=%b busy=%b a=%h want 0 0 10", mem_en[0], busy[0], mem_addr[0]);
        end
    endtask

    task automatic test_cpu_load();
        logic [3:0] s;
        logic       rv2;
        s = 4'd0;
        rv2 = 1'b0;
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h10; cpu_wdata[0] = 32'd0;
        #1;
        for (int i = 0; i < 4; i++) begin
            s[3-i] = cpu_stall[0];
            if (i == 2) rv2 = cpu_rvalid[0];
            if (i < 3) tick();
        end
        total++;
        if (s !== 4'b1110) begin
            bad++; $display("FAIL load_stall_seq got=%b want=1110", s);
        end
        total++;
        if ({rv2, cpu_rvalid[0], cpu_rdata[0]} !== {1'b0, 1'b1, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL load_rvalid got rv@2=%b rv@3=%b data=%h want 0 1 deadbeef", rv2, cpu_rvalid[0], cpu_rdata[0]);
        end
        cpu_req[0] = 1'b0;
        tick();
        total++;
        if ({cpu_rvalid[0], cpu_rdata[0], busy[0]} !== {1'b0, 32'hDEADBEEF, 1'b0}) begin
            bad++;
            $display("FAIL load_after got rv=%b data=%h busy=%b want 0 deadbeef 0", cpu_rvalid[0], cpu_rdata[0], busy[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [135:0] v;
        logic         seen;
        cpu_req[2] = 1'b1; cpu_we[2] = 1'b0; cpu_addr[2] = 32'h18;
        tick();
        tick();
        total++;
        if ({busy[2], mem_en[2]} !== 2'b10) begin
            bad++; $display("FAIL midread_in_wait got busy=%b en=%b want 1 0", busy[2], mem_en[2]);
        end
        cpu_req[2] = 1'b0;
        reset = 1'b0;
        #1;
        for (int l = 0; l < NL; l++) begin
            v = {mem_en[l], mem_we[l], mem_addr[l], mem_wdata[l], cpu_rdata[l], cpu_rvalid[l],
                 ext_rdata[l], ext_rvalid[l], ext_gnt[l], busy[l], owner[l], cpu_stall[l]};
            total++;
            if (v !== 136'd0) begin
                bad++; $display("FAIL midread_reset lane=%0d got=%h want=0", l, v);
            end
        end
        tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (cpu_rvalid[2] !== 1'b0 || busy[2] !== 1'b0) seen = 1'b1;
            tick();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL midread_no_rvalid got activity=%b want=0", seen);
        end
    endtask

    task automatic test_arbitration();
        logic [9:0] rec;
        int         n;
        int         gerr;
        rec = 10'd0; n = 0; gerr = 0;
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 32'h14; cpu_wdata[0] = 32'h11111111;
        ext_req[0] = 1'b1; ext_we[0] = 1'b1; ext_addr[0] = 32'h30; ext_wdata[0] = 32'h22222222;
        for (int t = 0; t < 60 && n < 10; t++) begin
            tick();
            if (mem_en[0] === 1'b1) begin
                rec = {rec[8:0], owner[0]};
                if (ext_gnt[0] !== owner[0]) gerr++;
                n++;
            end else if (ext_gnt[0] !== 1'b0) begin
                gerr++;
            end
        end
        total++;
        if (n != 10 || rec !== 10'b0000100001) begin
            bad++; $display("FAIL arb_order grants=%0d got=%b want 10 grants 0000100001", n, rec);
        end
        total++;
        if (gerr != 0) begin
            bad++; $display("FAIL arb_ext_gnt bad_cycles=%0d want=0", gerr);
        end
        cpu_req[0] = 1'b0; ext_req[0] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_ext_read();
        ext_req[0] = 1'b1; ext_we[0] = 1'b1; ext_addr[0] = 32'h20; ext_wdata[0] = 32'h12345678;
        tick();
        total++;
        if ({ext_gnt[0], owner[0], mem_en[0], mem_we[0]} !== 4'b1111) begin
            bad++;
            $display("FAIL ext_write_issue got gnt=%b own=%b en=%b we=%b want 1111", ext_gnt[0], owner[0], mem_en[0], mem_we[0]);
        end
        ext_req[0] = 1'b0;
        tick();
        ext_req[0] = 1'b1; ext_we[0] = 1'b0;
        tick();
        total++;
        if ({ext_gnt[0], mem_en[0], mem_we[0], mem_addr[0]} !== {3'b110, 32'h20}) begin
            bad++;
            $display("FAIL ext_read_issue got gnt=%b en=%b we=%b a=%h want 1 1 0 20", ext_gnt[0], mem_en[0], mem_we[0], mem_addr[0]);
        end
        ext_req[0] = 1'b0;
        tick();
        total++;
        if ({ext_gnt[0], ext_rvalid[0]} !== 2'b00) begin
            bad++; $display("FAIL ext_read_wait got gnt=%b rv=%b want 0 0", ext_gnt[0], ext_rvalid[0]);
        end
        tick();
        total++;
        if ({ext_rvalid[0], ext_rdata[0], cpu_rvalid[0]} !== {1'b1, 32'h12345678, 1'b0}) begin
            bad++;
            $display("FAIL ext_read_done got rv=%b data=%h cpu_rv=%b want 1 12345678 0", ext_rvalid[0], ext_rdata[0], cpu_rvalid[0]);
        end
        tick();
        total++;
        if ({ext_rvalid[0], ext_rdata[0]} !== {1'b0, 32'h12345678}) begin
            bad++; $display("FAIL ext_read_hold got rv=%b data=%h want 0 12345678", ext_rvalid[0], ext_rdata[0]);
        end
    endtask

    task automatic test_back_to_back(input int l);
        int          prev;
        int          wc;
        logic [31:0] exp_d;
        prev = 0;
        // back-to-back stores: one completion every 2 cycles
        for (int i = 0; i < 4; i++) begin
            cpu_req[l] = 1'b1; cpu_we[l] = 1'b1; cpu_addr[l] = 32'h40 + 32'(4 * i);
            cpu_wdata[l] = 32'hC0DE0000 | 32'(l << 8) | 32'(i);
            #1;
            wc = 0;
            while (cpu_stall[l] === 1'b1 && wc < 40) begin
                tick(); #1; wc++;
            end
            if (wc >= 40) begin
                total++; bad++; $display("FAIL b2b_store_timeout lane=%0d idx=%0d", l, i);
            end else if (i > 0) begin
                total++;
                if (cyc - prev != 2) begin
                    bad++; $display("FAIL b2b_store_spacing lane=%0d got=%0d want=2", l, cyc - prev);
                end
            end
            prev = cyc;
            tick();
        end
        // back-to-back loads: one completion every 3+RD_LAT cycles
        for (int i = 0; i < 4; i++) begin
            cpu_req[l] = 1'b1; cpu_we[l] = 1'b0; cpu_addr[l] = 32'h40 + 32'(4 * i);
            exp_d = 32'hC0DE0000 | 32'(l << 8) | 32'(i);
            #1;
            wc = 0;
            while (cpu_stall[l] === 1'b1 && wc < 40) begin
                tick(); #1; wc++;
            end
            total++;
            if (wc >= 40) begin
                bad++; $display("FAIL b2b_load_timeout lane=%0d idx=%0d", l, i);
            end else if ({cpu_rvalid[l], cpu_rdata[l]} !== {1'b1, exp_d}) begin
                bad++;
                $display("FAIL b2b_load_data lane=%0d idx=%0d got rv=%b data=%h want 1 %h", l, i, cpu_rvalid[l], cpu_rdata[l], exp_d);
            end
            if (wc < 40 && i > 0) begin
                total++;
                if (cyc - prev != 3 + lat_of(l)) begin
                    bad++;
                    $display("FAIL b2b_load_spacing lane=%0d got=%0d want=%0d", l, cyc - prev, 3 + lat_of(l));
                end
            end
            prev = cyc;
            tick();
        end
        cpu_req[l] = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_store();
        test_cpu_load();
        test_reset_mid_read();
        test_arbitration();
        test_ext_read();
        test_back_to_back(0);
        test_back_to_back(1);
        test_back_to_back(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
